// File: rtl/uart_tx_frame.sv
// UART transmitter: valid/ready word stream in, N/E/O parity, 1/2 stop bits out.
// A one-word holding register feeds the serialiser so consecutive frames abut.
module uart_tx_frame #(
  parameter int CLK_FREQ_HZ = 0,
  parameter int BAUD_RATE   = 0,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] word_in_data,
  input  logic                 word_in_valid,
  output logic                 word_in_ready,
  output logic                 busy,
  output logic                 bit_out
);

  // Divisor/clamp only keep elaboration legal while the rates are left unset.
  localparam int TPB_RAW       = CLK_FREQ_HZ / ((BAUD_RATE > 0) ? BAUD_RATE : 1);
  localparam int TICKS_PER_BIT = (TPB_RAW >= 2) ? TPB_RAW : 2;
  localparam int TW            = $clog2(TICKS_PER_BIT) + 1;
  localparam int BW            = $clog2(DATA_BITS);

  localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state      = S_IDLE;
  logic                 hold_valid = 1'b0;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shifter;
  logic                 parity_bit;
  logic [TW-1:0]        tick       = '0;
  logic [BW-1:0]        bit_cnt    = '0;
  logic                 line_q     = 1'b1;
  logic                 line;
  logic                 tick_last;
  logic                 stop_last;
  logic                 do_load;

  assign word_in_ready = !hold_valid;
  assign busy          = hold_valid || (state != S_IDLE);
  assign bit_out       = line_q;

  assign tick_last = (tick == LAST_TICK);
  assign stop_last = (bit_cnt == LAST_STOP);
  // Load from idle, or straight from the last stop tick so frames abut.
  assign do_load   = hold_valid &&
                     ((state == S_IDLE) || ((state == S_STOP) && tick_last && stop_last));

  always_comb begin
    line = 1'b1;
    case (state)
      S_START: line = 1'b0;
      S_DATA:  line = shifter[0];
      S_PAR:   line = parity_bit;
      default: line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      hold_valid <= 1'b0;
      tick       <= '0;
      bit_cnt    <= '0;
      line_q     <= 1'b1;
    end else begin
      line_q <= line;
      if (word_in_valid && word_in_ready) begin
        hold_data  <= word_in_data;
        hold_valid <= 1'b1;
      end
      if (do_load) begin
        shifter    <= hold_data;
        parity_bit <= (^hold_data) ^ ODD;
        hold_valid <= 1'b0;
        state      <= S_START;
        tick       <= '0;
        bit_cnt    <= '0;
      end else begin
        case (state)
          S_START: begin
            if (tick_last) begin
              tick  <= '0;
              state <= S_DATA;
            end else tick <= tick + 1'b1;
          end
          S_DATA: begin
            if (tick_last) begin
              tick    <= '0;
              shifter <= {1'b0, shifter[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= (PARITY != 0) ? S_PAR : S_STOP;
              end else bit_cnt <= bit_cnt + 1'b1;
            end else tick <= tick + 1'b1;
          end
          S_PAR: begin
            if (tick_last) begin
              tick  <= '0;
              state <= S_STOP;
            end else tick <= tick + 1'b1;
          end
          S_STOP: begin
            // bit_cnt doubles as the stop-bit index here.
            if (tick_last) begin
              tick <= '0;
              if (stop_last) begin
                bit_cnt <= '0;
                state   <= S_IDLE;
              end else bit_cnt <= bit_cnt + 1'b1;
            end else tick <= tick + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
